// File: rtl/clkgen_tick_pkg.sv
// clkgen_tick shared package: reset divisor, minimum divisor
// and per-channel output mode encodings.
package clkgen_tick_pkg;

   localparam int DEF_DIV_C = 50000;
   localparam int MIN_DIV   = 2;

   typedef enum logic {
      MODE_TICK = 1'b0,
      MODE_SQW  = 1'b1
   } mode_e;

endpackage

// File: rtl/clkgen_tick_if.sv
// clkgen_tick control/status bundle.
// master drives RUN/MODE/DIV_LOAD/DIV_IN/SYNC, slave drives OUT/PEND.
interface clkgen_tick_if #(
   parameter int NCH   = 4,
   parameter int DIV_W = 26
);

   logic [NCH-1:0]   RUN;
   logic [NCH-1:0]   MODE;
   logic [NCH-1:0]   DIV_LOAD;
   logic [DIV_W-1:0] DIV_IN;
   logic             SYNC;
   logic [NCH-1:0]   OUT;
   logic [NCH-1:0]   PEND;

   modport master (
      output RUN, MODE, DIV_LOAD, DIV_IN, SYNC,
      input  OUT, PEND
   );

   modport slave (
      input  RUN, MODE, DIV_LOAD, DIV_IN, SYNC,
      output OUT, PEND
   );

endinterface

// File: rtl/clkgen_chan.sv
// clkgen_chan: one divider channel with shadowed divisor.
// Ports: clk, rst_n, run, mode, load, div_in, sync -> out, pend.
module clkgen_chan
   import clkgen_tick_pkg::*;
#(
   parameter int DIV_W   = 26,
   parameter int DEF_DIV = DEF_DIV_C
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             mode,
   input  logic             load,
   input  logic [DIV_W-1:0] div_in,
   input  logic             sync,
   output logic             out,
   output logic             pend
);

   localparam logic [DIV_W-1:0] DEF_V = DIV_W'(DEF_DIV);
   localparam logic [DIV_W-1:0] MIN_V = DIV_W'(MIN_DIV);
   localparam logic [DIV_W-1:0] ONE_V = DIV_W'(1);

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] div_act;
   logic [DIV_W-1:0] div_shd;

   logic             wrap;
   logic             restart;
   logic             apply;
   logic [DIV_W-1:0] cnt_nxt;
   logic [DIV_W-1:0] act_nxt;
   logic [DIV_W-1:0] shd_nxt;
   logic             pend_nxt;
   logic             out_nxt;

   always_comb begin
      wrap     = 1'b0;
      restart  = 1'b0;
      apply    = 1'b0;
      cnt_nxt  = cnt + ONE_V;
      act_nxt  = div_act;
      shd_nxt  = div_shd;
      pend_nxt = pend;
      out_nxt  = 1'b0;

      wrap    = (cnt == div_act - ONE_V);
      // sync, idle and wrap all start a fresh period at cnt 0
      restart = sync | ~run | wrap;
      apply   = pend & restart;

      if (restart)
         cnt_nxt = '0;
      if (apply)
         act_nxt = div_shd;

      // a load in the apply cycle arms the next period, not this one
      if (load) begin
         shd_nxt  = (div_in < MIN_V) ? MIN_V : div_in;
         pend_nxt = 1'b1;
      end else if (apply) begin
         pend_nxt = 1'b0;
      end

      // tick marks a natural wrap only; a sync-truncated period
      // gives no pulse
      if (run) begin
         if (mode == MODE_SQW)
            out_nxt = (cnt_nxt < (act_nxt >> 1));
         else
            out_nxt = wrap & ~sync;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt     <= '0;
         div_act <= DEF_V;
         div_shd <= DEF_V;
         pend    <= 1'b0;
         out     <= 1'b0;
      end else begin
         cnt     <= cnt_nxt;
         div_act <= act_nxt;
         div_shd <= shd_nxt;
         pend    <= pend_nxt;
         out     <= out_nxt;
      end
   end

endmodule

// File: rtl/clkgen_tick.sv
// clkgen_tick: NCH-channel tick/clock-enable generator with reset sync.
// Ports: CLK50M, RSTN -> RSTN_SYNC; bus (slave) carries channel controls.
module clkgen_tick
   import clkgen_tick_pkg::*;
#(
   parameter int NCH     = 4,
   parameter int DIV_W   = 26,
   parameter int DEF_DIV = DEF_DIV_C
) (
   input  logic         CLK50M,
   input  logic         RSTN,
   output logic         RSTN_SYNC,
   clkgen_tick_if.slave bus
);

   // asserts with RSTN, releases on the 2nd clock edge after it
   logic [1:0] rst_sync;

   always_ff @(posedge CLK50M or negedge RSTN) begin
      if (!RSTN)
         rst_sync <= 2'b00;
      else
         rst_sync <= {rst_sync[0], 1'b1};
   end

   assign RSTN_SYNC = rst_sync[1];

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      clkgen_chan #(
         .DIV_W   (DIV_W),
         .DEF_DIV (DEF_DIV)
      ) u_chan (
         .clk    (CLK50M),
         .rst_n  (rst_sync[1]),
         .run    (bus.RUN[i]),
         .mode   (bus.MODE[i]),
         .load   (bus.DIV_LOAD[i]),
         .div_in (bus.DIV_IN),
         .sync   (bus.SYNC),
         .out    (bus.OUT[i]),
         .pend   (bus.PEND[i])
      );
   end

endmodule

// File: tb/tb_clkgen_tick.sv
// Self-checking bench for clkgen_tick.
// Table-driven cycle vectors plus hand sequences for corner cases.
module tb_clkgen_tick;

   logic CLK50M;
   logic RSTN;
   logic RSTN_SYNC;

   clkgen_tick_if #(.NCH(4), .DIV_W(26)) bus ();

   clkgen_tick #(
      .NCH     (4),
      .DIV_W   (26),
      .DEF_DIV (50000)
   ) dut (
      .CLK50M    (CLK50M),
      .RSTN      (RSTN),
      .RSTN_SYNC (RSTN_SYNC),
      .bus       (bus)
   );

   initial CLK50M = 1'b0;
   always #5 CLK50M = ~CLK50M;

   typedef struct {
      logic [3:0]  run;
      logic [3:0]  mode;
      logic [3:0]  load;
      logic [25:0] din;
      logic [3:0]  eout;
      logic [3:0]  epend;
   } vec_t;

   vec_t tbl [19];
   int   n_chk  = 0;
   int   n_fail = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK50M);
      #1;
   endtask

   task automatic drive(input logic [3:0] ld, input logic [25:0] d);
      bus.DIV_LOAD = ld;
      bus.DIV_IN   = d;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int ph;
      logic seen;

      RSTN         = 1'b0;
      bus.RUN      = 4'hF;
      bus.MODE     = 4'h0;
      bus.DIV_LOAD = 4'h0;
      bus.DIV_IN   = '0;
      bus.SYNC     = 1'b0;

      // reset state
      #2;
      chk("rst_out", 32'(bus.OUT), 0);
      chk("rst_pend", 32'(bus.PEND), 0);
      chk("rst_sync0", 32'(RSTN_SYNC), 0);
      step();
      step();
      chk("rst_hold_out", 32'(bus.OUT), 0);
      #2 RSTN = 1'b1;
      step();
      chk("rsync_edge1", 32'(RSTN_SYNC), 0);
      step();
      chk("rsync_edge2", 32'(RSTN_SYNC), 1);

      // default divisor: first tick 50000 edges after release
      seen = 1'b0;
      n    = 0;
      for (int i = 1; i <= 50005; i++) begin
         step();
         if (bus.OUT != 4'h0) begin
            n    = i;
            seen = 1'b1;
            break;
         end
      end
      chk("def_seen", 32'(seen), 1);
      chk("def_period", n, 50000);
      chk("def_all_ch", 32'(bus.OUT), 32'hF);
      chk("def_pend", 32'(bus.PEND), 0);
      step();
      chk("def_width", 32'(bus.OUT), 0);

      bus.RUN = 4'h0;
      step();

      // run, mode, load, din, out, pend
      tbl[0]  = '{4'h0, 4'h0, 4'h1, 26'd0, 4'h0, 4'h1};
      tbl[1]  = '{4'h0, 4'h0, 4'h1, 26'd1, 4'h0, 4'h1};
      tbl[2]  = '{4'h0, 4'h0, 4'h2, 26'd5, 4'h0, 4'h2};
      tbl[3]  = '{4'h0, 4'h0, 4'h0, 26'd0, 4'h0, 4'h0};
      tbl[4]  = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h2, 4'h0};
      tbl[5]  = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h1, 4'h0};
      tbl[6]  = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h0, 4'h0};
      tbl[7]  = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h1, 4'h0};
      tbl[8]  = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h2, 4'h0};
      tbl[9]  = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h3, 4'h0};
      tbl[10] = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h0, 4'h0};
      tbl[11] = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h1, 4'h0};
      tbl[12] = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h0, 4'h0};
      tbl[13] = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h3, 4'h0};
      tbl[14] = '{4'h3, 4'h2, 4'h0, 26'd0, 4'h2, 4'h0};
      tbl[15] = '{4'h3, 4'h3, 4'h0, 26'd0, 4'h1, 4'h0};
      tbl[16] = '{4'h3, 4'h3, 4'h0, 26'd0, 4'h0, 4'h0};
      tbl[17] = '{4'h3, 4'h3, 4'h0, 26'd0, 4'h1, 4'h0};
      tbl[18] = '{4'h0, 4'h3, 4'h0, 26'd0, 4'h0, 4'h0};

      for (int i = 0; i < 19; i++) begin
         bus.RUN  = tbl[i].run;
         bus.MODE = tbl[i].mode;
         drive(tbl[i].load, tbl[i].din);
         step();
         chk($sformatf("tbl%0d_out", i), 32'(bus.OUT), 32'(tbl[i].eout));
         chk($sformatf("tbl%0d_pend", i), 32'(bus.PEND),
             32'(tbl[i].epend));
      end
      drive(4'h0, 26'd0);
      bus.MODE = 4'h0;

      // glitch-free reload: div 10, load 4 at cnt 3
      drive(4'h1, 26'd10);
      step();
      drive(4'h0, 26'd0);
      step();
      bus.RUN = 4'h1;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus.OUT[0]) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rl_first_tick", 32'(seen), 1);
      step();
      step();
      step();
      drive(4'h1, 26'd4);
      step();
      drive(4'h0, 26'd0);
      chk("rl_pend_set", 32'(bus.PEND), 1);
      for (int i = 5; i <= 9; i++) begin
         step();
         chk($sformatf("rl_hold%0d_pend", i), 32'(bus.PEND), 1);
         chk($sformatf("rl_hold%0d_out", i), 32'(bus.OUT), 0);
      end
      step();
      chk("rl_wrap_out", 32'(bus.OUT), 1);
      chk("rl_wrap_pend", 32'(bus.PEND), 0);
      for (int k = 1; k <= 8; k++) begin
         step();
         chk($sformatf("rl_p4_%0d", k), 32'(bus.OUT),
             (k % 4 == 0) ? 1 : 0);
      end

      // load at a wrap: old shadow applies, new one stays pending
      drive(4'h1, 26'd6);
      step();
      drive(4'h0, 26'd0);
      chk("col_pend", 32'(bus.PEND), 1);
      step();
      step();
      chk("col_pre_out", 32'(bus.OUT), 0);
      drive(4'h1, 26'd3);
      step();
      drive(4'h0, 26'd0);
      chk("col_wrap_out", 32'(bus.OUT), 1);
      chk("col_wrap_pend", 32'(bus.PEND), 1);
      for (int k = 1; k <= 6; k++) begin
         step();
         chk($sformatf("col_p6_%0d", k), 32'(bus.OUT),
             (k == 6) ? 1 : 0);
      end
      chk("col_pend_clr", 32'(bus.PEND), 0);
      for (int k = 1; k <= 3; k++) begin
         step();
         chk($sformatf("col_p3_%0d", k), 32'(bus.OUT),
             (k == 3) ? 1 : 0);
      end

      // SYNC alignment: ch0 -> 7 (pending), ch1 = 3
      drive(4'h2, 26'd3);
      step();
      drive(4'h0, 26'd0);
      step();
      bus.RUN = 4'h3;
      ph = int'($urandom_range(1, 5));
      for (int i = 0; i < ph; i++)
         step();
      drive(4'h1, 26'd7);
      step();
      drive(4'h0, 26'd0);
      chk("sy_pend", 32'(bus.PEND), 1);
      bus.SYNC = 1'b1;
      step();
      bus.SYNC = 1'b0;
      chk("sy_no_tick", 32'(bus.OUT), 0);
      chk("sy_pend_clr", 32'(bus.PEND), 0);
      for (int s = 1; s <= 21; s++) begin
         step();
         chk($sformatf("sy_s%0d", s), 32'(bus.OUT),
             ((s % 7 == 0) ? 1 : 0) | ((s % 3 == 0) ? 2 : 0));
      end

      // reset mid-run with a pending divisor
      bus.RUN  = 4'hC;
      bus.MODE = 4'h4;
      step();
      step();
      drive(4'h8, 26'd4);
      step();
      drive(4'h0, 26'd0);
      chk("mr_pend_pre", 32'(bus.PEND), 32'h8);
      chk("mr_out_pre", 32'(bus.OUT), 32'h4);
      #2 RSTN = 1'b0;
      #1;
      chk("mr_out_async", 32'(bus.OUT), 0);
      chk("mr_pend_async", 32'(bus.PEND), 0);
      chk("mr_rsync_async", 32'(RSTN_SYNC), 0);
      step();
      step();
      #2 RSTN = 1'b1;
      step();
      chk("mr_rsync_e1", 32'(RSTN_SYNC), 0);
      step();
      chk("mr_rsync_e2", 32'(RSTN_SYNC), 1);
      chk("mr_out_rel", 32'(bus.OUT), 0);
      for (int k = 1; k <= 200; k++) begin
         step();
         chk($sformatf("mr_def_%0d", k), 32'(bus.OUT), 32'h4);
      end
      chk("mr_pend_lost", 32'(bus.PEND), 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
